// File: rtl/ddr_pkg.sv
// Shared DDR4 refresh types, the REF command encoding and the
// bank-walk helper used by the refresh sequencer.
package ddr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        WAIT_RFC
    } ref_state_t;

    localparam logic [16:0] REF_ADDR_DEFAULT = 17'h04001;

    typedef logic [7:0] idx_t;

    typedef struct packed {
        idx_t rank;
        idx_t bg;
        idx_t ba;
        logic last;
    } bank_pos_t;

    // Advance rank/bg/ba by one command; order picks which of bg/ba is the
    // inner loop. The *_max limits collapse to 0 in all-bank mode.
    function automatic bank_pos_t next_bank(
        input idx_t rank,
        input idx_t bg,
        input idx_t ba,
        input logic order,
        input idx_t rank_max,
        input idx_t bg_max,
        input idx_t ba_max
    );
        bank_pos_t p;
        logic      in_wrap;
        logic      out_wrap;
        p.rank = rank;
        p.bg   = bg;
        p.ba   = ba;
        p.last = (rank == rank_max) && (bg == bg_max) && (ba == ba_max);
        if (!order) begin
            in_wrap  = (ba == ba_max);
            out_wrap = (bg == bg_max);
            p.ba     = in_wrap ? '0 : ba + idx_t'(1);
            if (in_wrap) p.bg = out_wrap ? '0 : bg + idx_t'(1);
        end else begin
            in_wrap  = (bg == bg_max);
            out_wrap = (ba == ba_max);
            p.bg     = in_wrap ? '0 : bg + idx_t'(1);
            if (in_wrap) p.ba = out_wrap ? '0 : ba + idx_t'(1);
        end
        if (in_wrap && out_wrap) p.rank = p.last ? '0 : rank + idx_t'(1);
        return p;
    endfunction

endpackage

// File: rtl/refresh_interleaver_if.sv
// Command-bus and host-side signals of the refresh sequencer.
// master = sequencer, slave = host / DIMM model side.
interface refresh_interleaver_if #(
    parameter int RANKS       = 1,
    parameter int BGWIDTH     = 2,
    parameter int BAWIDTH     = 2,
    parameter int ADDRWIDTH   = 17,
    parameter int MAX_PENDING = 8
);
    localparam int PW = $clog2(MAX_PENDING + 1);

    logic                 bus_idle;
    logic                 ref_now;
    logic                 mode_perbank;
    logic                 order_interleave;
    logic [RANKS-1:0]     cs_n;
    logic                 act_n;
    logic [ADDRWIDTH-1:0] A;
    logic [BGWIDTH-1:0]   bg;
    logic [BAWIDTH-1:0]   ba;
    logic                 ref_busy;
    logic                 urgent;
    logic [PW-1:0]        pending;
    logic                 burst_done;

    modport master (
        input  bus_idle, ref_now, mode_perbank, order_interleave,
        output cs_n, act_n, A, bg, ba,
        output ref_busy, urgent, pending, burst_done
    );

    modport slave (
        output bus_idle, ref_now, mode_perbank, order_interleave,
        input  cs_n, act_n, A, bg, ba,
        input  ref_busy, urgent, pending, burst_done
    );

endinterface

// File: rtl/refresh_timer.sv
// tREFI interval counter plus the saturating count of outstanding
// refresh obligations (and its urgent flag).
module refresh_timer #(
    parameter int TREFI       = 64,
    parameter int MAX_PENDING = 8,
    parameter int PW          = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ref_now,
    input  logic          done_dec,
    output logic [PW-1:0] pending,
    output logic          urgent
);
    localparam int CW = (TREFI > 1) ? $clog2(TREFI) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          urgent_q, urgent_d;
    logic          tick;
    int            sum;

    // Interval wrap and clamped pending arithmetic (tick+ref_now may add 2)
    always_comb begin
        tick  = (cnt_q == CW'(TREFI - 1));
        cnt_d = tick ? '0 : cnt_q + CW'(1);
        sum   = int'(pending_q) + int'(tick) + int'(ref_now) - int'(done_dec);
        if (sum > MAX_PENDING) sum = MAX_PENDING;
        if (sum < 0) sum = 0;
        pending_d = PW'(sum);
        urgent_d  = (sum == MAX_PENDING);
    end

    // Counter and accumulator registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            pending_q <= '0;
            urgent_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            urgent_q  <= urgent_d;
        end
    end

    assign pending = pending_q;
    assign urgent  = urgent_q;

endmodule

// File: rtl/refresh_interleaver.sv
// Refresh command sequencer: walks ranks/bank groups/banks issuing REF
// commands, then holds the bus for tRFC before handing it back.
module refresh_interleaver
    import ddr_pkg::*;
#(
    parameter int                   RANKS       = 1,
    parameter int                   BGWIDTH     = 2,
    parameter int                   BAWIDTH     = 2,
    parameter int                   ADDRWIDTH   = 17,
    parameter logic [ADDRWIDTH-1:0] REF_ADDR    = REF_ADDR_DEFAULT,
    parameter int                   TREFI       = 64,
    parameter int                   TRFC        = 36,
    parameter int                   CMD_GAP     = 0,
    parameter int                   MAX_PENDING = 8
) (
    input  logic                  ck_t,
    input  logic                  reset,
    refresh_interleaver_if.master bus
);
    localparam int   PW       = $clog2(MAX_PENDING + 1);
    localparam idx_t RANK_MAX = idx_t'(RANKS - 1);
    localparam idx_t BG_MAX   = idx_t'((1 << BGWIDTH) - 1);
    localparam idx_t BA_MAX   = idx_t'((1 << BAWIDTH) - 1);
    localparam logic [15:0] GAP_END = 16'(CMD_GAP - 1);
    localparam logic [15:0] RFC_END = 16'(TRFC - 1);

    ref_state_t  state_q, state_d;
    idx_t        rank_q, rank_d;
    idx_t        bg_q, bg_d;
    idx_t        ba_q, ba_d;
    logic        mode_q, mode_d;
    logic        order_q, order_d;
    logic [15:0] cnt_q, cnt_d;
    bank_pos_t   nxt;
    logic [PW-1:0] pending_w;
    logic        urgent_w;
    logic        done_dec;

    refresh_timer #(
        .TREFI       (TREFI),
        .MAX_PENDING (MAX_PENDING),
        .PW          (PW)
    ) u_timer (
        .clk      (ck_t),
        .reset    (reset),
        .ref_now  (bus.ref_now),
        .done_dec (done_dec),
        .pending  (pending_w),
        .urgent   (urgent_w)
    );

    // Next bank position; all-bank mode walks ranks only
    always_comb begin
        nxt = next_bank(rank_q, bg_q, ba_q, order_q, RANK_MAX,
                        mode_q ? BG_MAX : idx_t'(0),
                        mode_q ? BA_MAX : idx_t'(0));
    end

    // State, indices, latched burst options and gap/tRFC counter
    always_ff @(posedge ck_t) begin
        if (reset) begin
            state_q <= IDLE;
            rank_q  <= '0;
            bg_q    <= '0;
            ba_q    <= '0;
            mode_q  <= 1'b0;
            order_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rank_q  <= rank_d;
            bg_q    <= bg_d;
            ba_q    <= ba_d;
            mode_q  <= mode_d;
            order_q <= order_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        rank_d  = rank_q;
        bg_d    = bg_q;
        ba_d    = ba_q;
        mode_d  = mode_q;
        order_d = order_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pending_w != '0 && (bus.bus_idle || urgent_w)) begin
                    state_d = ISSUE;
                    mode_d  = bus.mode_perbank;
                    order_d = bus.order_interleave;
                    rank_d  = '0;
                    bg_d    = '0;
                    ba_d    = '0;
                end
            end
            ISSUE: begin
                rank_d = nxt.rank;
                bg_d   = nxt.bg;
                ba_d   = nxt.ba;
                cnt_d  = '0;
                if (nxt.last) state_d = WAIT_RFC;
                else if (CMD_GAP > 0) state_d = GAP;
            end
            GAP: begin
                if (cnt_q == GAP_END) state_d = ISSUE;
                else cnt_d = cnt_q + 16'd1;
            end
            WAIT_RFC: begin
                if (cnt_q == RFC_END) state_d = IDLE;
                else cnt_d = cnt_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Command-bus and status outputs decoded from the state
    always_comb begin
        bus.cs_n       = '1;
        bus.A          = '0;
        bus.bg         = '0;
        bus.ba         = '0;
        bus.ref_busy   = 1'b0;
        bus.burst_done = 1'b0;
        done_dec       = 1'b0;
        unique case (state_q)
            IDLE: ;
            ISSUE: begin
                bus.ref_busy = 1'b1;
                bus.cs_n     = ~(RANKS'(1) << rank_q);
                bus.A        = REF_ADDR;
                bus.bg       = bg_q[BGWIDTH-1:0];
                bus.ba       = ba_q[BAWIDTH-1:0];
            end
            GAP: bus.ref_busy = 1'b1;
            WAIT_RFC: begin
                bus.ref_busy   = 1'b1;
                done_dec       = (cnt_q == RFC_END);
                bus.burst_done = done_dec;
            end
            default: ;
        endcase
    end

    assign bus.act_n   = 1'b1;
    assign bus.pending = pending_w;
    assign bus.urgent  = urgent_w;

endmodule

// File: tb/tb_refresh_interleaver.sv
// Two sequencer configurations driven by shared directed + random stimulus,
// each checked cycle by cycle against a schedule-queue reference model.
module tb_refresh_interleaver;

    localparam int TREFI = 64;
    localparam int TRFC  = 36;
    localparam int MAXP  = 8;
    localparam int NBG   = 4;
    localparam int NBA   = 4;
    localparam int REFA  = 'h04001;

    typedef struct {
        int rank;
        int bg;
        int ba;
        bit done;
    } slot_t;

    int NR  [2] = '{1, 2};
    int GAPC[2] = '{0, 3};

    logic clk = 1'b0;
    logic rst;
    logic bus_idle, ref_now, mode, order;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    slot_t sched [2][$];
    int    pend  [2];
    int    tcnt  [2];

    always #5 clk = ~clk;

    refresh_interleaver_if #(.RANKS(1)) if0 ();
    refresh_interleaver_if #(.RANKS(2)) if1 ();

    assign if0.bus_idle         = bus_idle;
    assign if0.ref_now          = ref_now;
    assign if0.mode_perbank     = mode;
    assign if0.order_interleave = order;
    assign if1.bus_idle         = bus_idle;
    assign if1.ref_now          = ref_now;
    assign if1.mode_perbank     = mode;
    assign if1.order_interleave = order;

    refresh_interleaver d0 (
        .ck_t  (clk),
        .reset (rst),
        .bus   (if0)
    );

    refresh_interleaver #(
        .RANKS   (2),
        .CMD_GAP (3)
    ) d1 (
        .ck_t  (clk),
        .reset (rst),
        .bus   (if1)
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic slot_t mk(input int r, input int g, input int b,
                                 input bit d);
        slot_t s;
        s.rank = r;
        s.bg   = g;
        s.ba   = b;
        s.done = d;
        return s;
    endfunction

    // Whole burst laid out as one slot per cycle
    task automatic build(input int k, input bit pb, input bit ord);
        slot_t cmds[$];
        for (int r = 0; r < NR[k]; r++) begin
            if (!pb) cmds.push_back(mk(r, 0, 0, 0));
            else if (!ord) begin
                for (int g = 0; g < NBG; g++)
                    for (int b = 0; b < NBA; b++)
                        cmds.push_back(mk(r, g, b, 0));
            end else begin
                for (int b = 0; b < NBA; b++)
                    for (int g = 0; g < NBG; g++)
                        cmds.push_back(mk(r, g, b, 0));
            end
        end
        foreach (cmds[i]) begin
            sched[k].push_back(cmds[i]);
            if (i < cmds.size() - 1)
                repeat (GAPC[k]) sched[k].push_back(mk(-1, 0, 0, 0));
        end
        for (int i = 0; i < TRFC; i++)
            sched[k].push_back(mk(-1, 0, 0, i == TRFC - 1));
    endtask

    task automatic advance(input int k);
        bit idle_st, done, tick;
        int old;
        if (rst) begin
            pend[k] = 0;
            tcnt[k] = 0;
            sched[k].delete();
            return;
        end
        idle_st = (sched[k].size() == 0);
        done    = 1'b0;
        if (!idle_st) begin
            done = sched[k][0].done;
            void'(sched[k].pop_front());
        end
        tick    = (tcnt[k] == TREFI - 1);
        tcnt[k] = (tcnt[k] + 1) % TREFI;
        old     = pend[k];
        pend[k] = old + int'(tick) + int'(ref_now) - int'(done);
        if (pend[k] > MAXP) pend[k] = MAXP;
        if (pend[k] < 0) pend[k] = 0;
        if (idle_st && old != 0 && (bus_idle || old == MAXP))
            build(k, mode, order);
    endtask

    task automatic check_dut(input int k, input logic [1:0] cs,
                             input logic act, input logic [16:0] a,
                             input logic [1:0] g, input logic [1:0] b,
                             input logic busy, input logic urg,
                             input logic [3:0] pd, input logic dn);
        slot_t s;
        bit    have;
        int    ecs;
        string p;
        have = (sched[k].size() != 0);
        s    = have ? sched[k][0] : mk(-1, 0, 0, 0);
        ecs  = (1 << NR[k]) - 1;
        if (s.rank >= 0) ecs = ecs & ~(1 << s.rank);
        p = $sformatf("d%0d@%0d", k, cyc);
        chk({p, " cs_n"}, int'(cs), ecs);
        chk({p, " act_n"}, int'(act), 1);
        chk({p, " A"}, int'(a), (s.rank >= 0) ? REFA : 0);
        chk({p, " bg"}, int'(g), s.bg);
        chk({p, " ba"}, int'(b), s.ba);
        chk({p, " ref_busy"}, int'(busy), int'(have));
        chk({p, " urgent"}, int'(urg), int'(pend[k] == MAXP));
        chk({p, " pending"}, int'(pd), pend[k]);
        chk({p, " burst_done"}, int'(dn), int'(have && s.done));
    endtask

    task automatic step();
        @(negedge clk);
        check_dut(0, {1'b0, if0.cs_n}, if0.act_n, if0.A, if0.bg, if0.ba,
                  if0.ref_busy, if0.urgent, if0.pending, if0.burst_done);
        check_dut(1, if1.cs_n, if1.act_n, if1.A, if1.bg, if1.ba,
                  if1.ref_busy, if1.urgent, if1.pending, if1.burst_done);
        advance(0);
        advance(1);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_burst(input int lead, input int tail);
        repeat (lead) step();
        ref_now = 1'b1;
        step();
        ref_now = 1'b0;
        repeat (tail) step();
    endtask

    initial begin
        rst      = 1'b1;
        bus_idle = 1'b1;
        ref_now  = 1'b0;
        mode     = 1'b1;
        order    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0;
            tcnt[k] = 0;
        end
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;

        // per-bank, bg-major
        do_reset();
        pulse_burst(9, 70);

        // per-bank, bg-interleaved
        order = 1'b1;
        do_reset();
        pulse_burst(9, 70);

        // all-bank
        mode  = 1'b0;
        order = 1'b0;
        do_reset();
        pulse_burst(9, 60);

        // host never idle: saturate, then urgent burst
        mode     = 1'b1;
        bus_idle = 1'b0;
        do_reset();
        repeat (9 * TREFI + 80) step();
        bus_idle = 1'b1;

        // reset lands on the 5th per-bank command of d0
        do_reset();
        pulse_burst(9, 5);
        do_reset();
        repeat (20) step();

        // burst_done coincides with a tREFI tick
        do_reset();
        pulse_burst(10, 70);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus_idle = ($urandom_range(0, 9) < 7);
            ref_now  = ($urandom_range(0, 19) == 0);
            mode     = 1'($urandom_range(0, 1));
            order    = 1'($urandom_range(0, 1));
            rst      = ($urandom_range(0, 499) == 0);
            step();
        end
        rst     = 1'b0;
        ref_now = 1'b0;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
